// File: rtl/adc_avg_filter.sv
// adc_avg_filter: moving-average filter for one 12-bit ADC channel.
// Keeps the last N = 2**DEPTH_LOG2 samples in a circular buffer with a running
// sum. It publishes the mean, a PWM duty word, an LED thermometer bar and an
// optional hysteretic alarm.
// Optional feature macro: ADC_FILT_ALARM_EN (alarm comparators; ALARM is tied 0 otherwise).
//
// Handshake: SAMPLE is taken on any rising edge where SAMPLE_VALID=1 and
// CLEAR=0. There is no backpressure. AVG_VALID is a one-cycle strobe in the
// cycle after the accepted sample; AVG/DUTY/LEVEL/ALARM change only with it.
module adc_avg_filter #(
  parameter int          DEPTH_LOG2 = 3,
  parameter logic [11:0] ALARM_HI   = 12'd3000,
  parameter logic [11:0] ALARM_LO   = 12'd2500
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        CLEAR,
  input  logic [11:0] SAMPLE,
  input  logic        SAMPLE_VALID,
  output logic [11:0] AVG,
  output logic        AVG_VALID,
  output logic [6:0]  DUTY,
  output logic [7:0]  LEVEL,
  output logic        ALARM,
  output logic        STATE_DBG
);

  localparam int N  = 1 << DEPTH_LOG2;
  localparam int SW = 12 + DEPTH_LOG2;

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t                state_q;
  logic [DEPTH_LOG2-1:0] fill_q;
  logic [DEPTH_LOG2-1:0] wptr_q;
  logic [SW-1:0]         sum_q;
  logic [11:0]           buf_q [N];
  logic [11:0]           avg_q;
  logic                  avg_valid_q;
  logic [6:0]            duty_q;
  logic [7:0]            level_q;

  logic                  accept;
  logic                  publish;
  logic [SW-1:0]         sum_d;
  logic [11:0]           avg_d;
  logic [12:0]           k_wide;
  logic [7:0]            level_d;

  // Next sum, next mean and whether this sample completes a window.
  always_comb begin
    accept  = SAMPLE_VALID & ~CLEAR;
    sum_d   = sum_q + SW'(SAMPLE) - SW'(buf_q[wptr_q]);
    avg_d   = 12'(sum_d >> DEPTH_LOG2);
    publish = accept & ((state_q == RUN) || (fill_q == DEPTH_LOG2'(N - 1)));
    k_wide  = ({1'b0, avg_d} + 13'd256) >> 9;
    level_d = '0;
    // A bit is lit when k exceeds its index; the 8-bit bar saturates k at 8.
    for (int i = 0; i < 8; i++) begin
      level_d[i] = (k_wide > 13'(i));
    end
  end

  // FILL/RUN sequencing: count the first N samples after reset or CLEAR.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= FILL;
      fill_q  <= '0;
    end else if (CLEAR) begin
      state_q <= FILL;
      fill_q  <= '0;
    end else if (accept && state_q == FILL) begin
      fill_q <= fill_q + DEPTH_LOG2'(1);
      if (fill_q == DEPTH_LOG2'(N - 1)) begin
        state_q <= RUN;
      end
    end
  end

  // Circular buffer, write pointer and running sum.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      wptr_q <= '0;
      sum_q  <= '0;
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
    end else if (CLEAR) begin
      wptr_q <= '0;
      sum_q  <= '0;
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
    end else if (accept) begin
      sum_q          <= sum_d;
      buf_q[wptr_q]  <= SAMPLE;
      wptr_q         <= wptr_q + DEPTH_LOG2'(1);
    end
  end

  // Registered mean and derived display words; held across CLEAR.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      duty_q      <= '0;
      level_q     <= '0;
    end else begin
      avg_valid_q <= publish;
      if (publish) begin
        avg_q   <= avg_d;
        duty_q  <= avg_d[11:5];
        level_q <= level_d;
      end
    end
  end

`ifdef ADC_FILT_ALARM_EN
  logic alarm_q;

  // Hysteretic alarm, re-evaluated only when a new mean is published.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      alarm_q <= 1'b0;
    end else if (publish) begin
      if (avg_d >= ALARM_HI) begin
        alarm_q <= 1'b1;
      end else if (avg_d < ALARM_LO) begin
        alarm_q <= 1'b0;
      end
    end
  end

  assign ALARM = alarm_q;
`else
  assign ALARM = 1'b0;
`endif

  assign AVG       = avg_q;
  assign AVG_VALID = avg_valid_q;
  assign DUTY      = duty_q;
  assign LEVEL     = level_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_adc_avg_filter.sv
// tb_adc_avg_filter: self-checking bench for adc_avg_filter (defaults, N=8).
module tb_adc_avg_filter;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [11:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic [11:0] avg;
  logic        avg_valid;
  logic [6:0]  duty;
  logic [7:0]  level;
  logic        alarm;
  logic        state_dbg;

  adc_avg_filter dut (
    .CLOCK_50    (clk),
    .RESET       (rst),
    .CLEAR       (clear),
    .SAMPLE      (sample),
    .SAMPLE_VALID(sample_valid),
    .AVG         (avg),
    .AVG_VALID   (avg_valid),
    .DUTY        (duty),
    .LEVEL       (level),
    .ALARM       (alarm),
    .STATE_DBG   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

`ifdef ADC_FILT_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  // ---------------- reference model ----------------
  logic [11:0] win[$];        // samples accepted since last restart, newest last
  logic [27:0] exp_q[$];      // {avg, duty, level, alarm}
  int          exp_cyc_q[$];
  int          m_avg = 0;
  int          m_alarm = 0;

  function automatic logic [7:0] bar_of(int a);
    int k;
    logic [7:0] b;
    k = (a + 256) / 512;
    if (k > 8) k = 8;
    b = '0;
    for (int i = 0; i < k; i++) b[i] = 1'b1;
    return b;
  endfunction

  function automatic logic [27:0] pack_exp(int a, int al);
    logic [11:0] a12;
    logic [6:0]  d7;
    a12 = 12'(a);
    d7  = 7'(a / 32);
    return {a12, d7, bar_of(a), al[0]};
  endfunction

  task automatic model_restart();
    win.delete();
  endtask

  task automatic model_reset();
    win.delete();
    m_avg   = 0;
    m_alarm = 0;
  endtask

  task automatic model_accept(input logic [11:0] s);
    int sum;
    win.push_back(s);
    if (win.size() > N) void'(win.pop_front());
    if (win.size() == N) begin
      sum = 0;
      foreach (win[i]) sum += win[i];
      m_avg = sum / N;
      if (ALARM_ON) begin
        if (m_avg >= 3000) m_alarm = 1;
        else if (m_avg < 2500) m_alarm = 0;
      end
      exp_q.push_back(pack_exp(m_avg, m_alarm));
      exp_cyc_q.push_back(cyc + 1);
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_hold(input string name);
    chk({name, "_avg"},   avg,   m_avg);
    chk({name, "_duty"},  duty,  m_avg / 32);
    chk({name, "_level"}, level, bar_of(m_avg));
    chk({name, "_alarm"}, alarm, m_alarm);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && avg_valid === 1'b1) begin
      logic [27:0] e;
      int          ec;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_avg_valid: got AVG=%0d with no pending result (cycle %0d)", avg, cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("sb_cycle", cyc, ec);
        chk("sb_avg",   avg,   e[27:16]);
        chk("sb_duty",  duty,  e[15:9]);
        chk("sb_level", level, e[8:1]);
        chk("sb_alarm", alarm, e[0]);
      end
    end else if (!rst && exp_cyc_q.size() != 0 && exp_cyc_q[0] < cyc) begin
      total++;
      bad++;
      $display("FAIL missing_avg_valid: got none expected one at cycle %0d (now %0d)", exp_cyc_q[0], cyc);
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic strobe(input logic [11:0] s);
    @(posedge clk);
    #1;
    clear        = 1'b0;
    sample       = s;
    sample_valid = 1'b1;
    model_accept(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      clear        = 1'b0;
      sample       = 12'($urandom_range(0, 4095));
    end
  endtask

  task automatic clear_with_sample(input logic [11:0] s);
    @(posedge clk);
    #1;
    clear        = 1'b1;
    sample       = s;
    sample_valid = 1'b1;
    model_restart();
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    idle(2);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #35;
    chk("rst_avg",   avg, 0);
    chk("rst_valid", avg_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_state", state_dbg, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Fill with 1000: exactly one result after the 8th strobe.
    for (int i = 0; i < N; i++) strobe(12'd1000);
    idle(1);
    chk("fill_avg", avg, 1000);
    chk("fill_duty", duty, 31);
    chk("fill_level", level, 8'b0000_0011);
    chk("fill_alarm", alarm, 0);
    chk("run_state", state_dbg, 1);

    // Step to full scale: alarm threshold crossing.
    for (int i = 1; i <= N; i++) begin
      strobe(12'd4095);
      idle(1);
      if (i == 1) chk("step1_avg", avg, 1386);
      if (i == 5) begin chk("step5_avg", avg, 2934); chk("step5_alarm", alarm, 0); end
      if (i == 6) begin chk("step6_avg", avg, 3321); chk("step6_alarm", alarm, ALARM_ON ? 1 : 0); end
      if (i == 8) begin
        chk("step8_avg", avg, 4095);
        chk("step8_duty", duty, 127);
        chk("step8_level", level, 8'hFF);
      end
    end

    // Step to zero: hysteresis band.
    for (int i = 1; i <= 4; i++) begin
      strobe(12'd0);
      idle(1);
      if (i == 3) begin chk("fall3_avg", avg, 2559); chk("fall3_alarm", alarm, ALARM_ON ? 1 : 0); end
      if (i == 4) begin chk("fall4_avg", avg, 2047); chk("fall4_alarm", alarm, 0); end
    end

    // CLEAR coincident with a sample: dropped, outputs hold, refill needed.
    clear_with_sample(12'd4000);
    idle(2);
    chk_hold("clear_hold");
    chk("clear_state", state_dbg, 0);
    for (int i = 0; i < N; i++) strobe(12'(100 * i + 7));
    idle(1);
    chk("clear_refill_avg", avg, (7 * 8 + 100 * 28) / 8);

    // Async reset after 5 fill samples.
    clear_with_sample(12'd0);
    for (int i = 0; i < 5; i++) strobe(12'd3500);
    idle(1);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_avg", avg, 0);
    chk("midrst_duty", duty, 0);
    chk("midrst_level", level, 0);
    chk("midrst_valid", avg_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) strobe(12'(200 + i));
    idle(1);
    chk("postrst_avg", avg, 203);

    // Back-to-back ramp 0..19 in RUN.
    for (int i = 0; i < 20; i++) strobe(12'(i));
    idle(2);
    chk("ramp_last_avg", avg, (12 + 19) * 8 / 2 / 8);
    drain();

    // Randomized traffic with gaps and occasional CLEAR.
    for (int t = 0; t < 400; t++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) clear_with_sample(12'($urandom_range(0, 4095)));
      else if (r < 60) strobe(12'($urandom_range(0, 4095)));
      else if (r < 75) strobe(($urandom_range(0, 1) != 0) ? 12'd4095 : 12'($urandom_range(2400, 3100)));
      else idle(1);
    end
    idle(1);
    drain();
    chk_hold("final_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
